// File: rtl/mod_counter_pkg.sv
// Shared definitions for the multi-digit BCD modulo counter:
// step-mode encodings, seven-segment patterns and a BCD helper.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_INC1 = 2'b01,
        MODE_INC2 = 2'b10,
        MODE_DEC1 = 2'b11
    } mode_e;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Elaboration-time only: turns a parameter into up to six BCD digits.
    function automatic logic [23:0] to_bcd(input int unsigned val);
        int unsigned v;
        logic [23:0] r;
        v = val;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// One BCD digit to an active-low seven-segment pattern (gfedcba).
// Only instantiated when MOD_COUNTER_SEG7_EN is defined.
module seg7_digit_decoder
    import mod_counter_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/multi_digit_mod_counter.sv
// Multi-digit BCD up/down modulo counter with load and wrap/error pulses.
// Define MOD_COUNTER_SEG7_EN to add the HEX seven-segment outputs.
module multi_digit_mod_counter
    import mod_counter_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MAX_COUNT = 99
) (
    input  logic                  Clock,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Cout,
    output logic                  wrap,
    output logic                  load_err
`ifdef MOD_COUNTER_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   HEX
`endif
);

    localparam int W = 4 * DIGITS;

    localparam logic [23:0] MAX_FULL = to_bcd(MAX_COUNT);
    localparam logic [23:0] MM1_FULL = to_bcd(MAX_COUNT - 1);

    localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];
    localparam logic [W-1:0] MM1_BCD = MM1_FULL[W-1:0];
    localparam logic [W-1:0] ONE_BCD = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;

    logic [W-1:0] inc_r;
    logic [W-1:0] dec_r;
    logic         ld_digits_ok;
    logic         ld_ok;

    // Per-digit ripple carry/borrow; the step never exceeds 2.
    always_comb begin : ripple
        logic [1:0] c;
        logic       b;
        logic [4:0] t;
        inc_r = '0;
        dec_r = '0;
        c = (mode == MODE_INC2) ? 2'd2 : 2'd1;
        b = 1'b1;
        t = '0;
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, cnt_q[4*i +: 4]} + {3'b000, c};
            if (t > 5'd9) begin
                inc_r[4*i +: 4] = 4'(t - 5'd10);
                c = 2'd1;
            end else begin
                inc_r[4*i +: 4] = t[3:0];
                c = 2'd0;
            end
            if (b && cnt_q[4*i +: 4] == 4'd0) begin
                dec_r[4*i +: 4] = 4'd9;
                b = 1'b1;
            end else begin
                dec_r[4*i +: 4] = cnt_q[4*i +: 4] - {3'b000, b};
                b = 1'b0;
            end
        end
    end

    // Valid BCD vectors order the same as their decimal values.
    always_comb begin
        ld_digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                ld_digits_ok = 1'b0;
            end
        end
        ld_ok = ld_digits_ok && (load_val <= MAX_BCD);
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            if (ld_ok) begin
                cnt_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            case (mode)
                MODE_INC1: begin
                    if (cnt_q == MAX_BCD) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = inc_r;
                    end
                end
                MODE_INC2: begin
                    if (cnt_q == MAX_BCD) begin
                        cnt_d  = ONE_BCD;
                        wrap_d = 1'b1;
                    end else if (cnt_q == MM1_BCD) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = inc_r;
                    end
                end
                MODE_DEC1: begin
                    if (cnt_q == '0) begin
                        cnt_d  = MAX_BCD;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = dec_r;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Cout     = cnt_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

`ifdef MOD_COUNTER_SEG7_EN
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_digit_decoder u_dec (
            .bcd (cnt_q[4*g +: 4]),
            .seg (HEX[7*g +: 7])
        );
    end
`endif

endmodule

// File: tb/tb_multi_digit_mod_counter.sv
// Directed self-checking bench for multi_digit_mod_counter
// (DIGITS=2, MAX_COUNT=59).
module tb_multi_digit_mod_counter;

    logic        Clock;
    logic        resetn;
    logic        en;
    logic [1:0]  mode;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  Cout;
    logic        wrap;
    logic        load_err;
`ifdef MOD_COUNTER_SEG7_EN
    logic [13:0] HEX;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    multi_digit_mod_counter #(
        .DIGITS    (2),
        .MAX_COUNT (59)
    ) dut (
        .Clock    (Clock),
        .resetn   (resetn),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .Cout     (Cout),
        .wrap     (wrap),
        .load_err (load_err)
`ifdef MOD_COUNTER_SEG7_EN
        ,
        .HEX      (HEX)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge for sampling.
    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drive(input logic l, input logic [7:0] lv,
                         input logic e, input logic [1:0] m);
        load     = l;
        load_val = lv;
        en       = e;
        mode     = m;
    endtask

    initial begin
        logic [7:0] exp_bcd;
        int         e;
        drive(1'b0, 8'h00, 1'b0, 2'b00);
        resetn = 1'b0;
        #12;
        chk("rst_cout", 32'(Cout), 32'h00);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_err", 32'(load_err), 32'h0);
`ifdef MOD_COUNTER_SEG7_EN
        chk("rst_hex", 32'(HEX), 32'h2040);
`endif
        @(negedge Clock);
        resetn = 1'b1;

        // 60 increments: 01..59 then 00 with a single wrap.
        drive(1'b0, 8'h00, 1'b1, 2'b01);
        for (int i = 0; i < 60; i++) begin
            step();
            e = (i + 1) % 60;
            exp_bcd = {4'(e / 10), 4'(e % 10)};
            chk("inc1_cout", 32'(Cout), 32'(exp_bcd));
            chk("inc1_wrap", 32'(wrap), (e == 0) ? 32'h1 : 32'h0);
        end

        drive(1'b1, 8'h58, 1'b0, 2'b00);
        step();
        chk("ld58", 32'(Cout), 32'h58);
        chk("ld58_wrap", 32'(wrap), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 2'b10);
        step();
        chk("inc2_a", 32'(Cout), 32'h00);
        chk("inc2_a_wrap", 32'(wrap), 32'h1);
        step();
        chk("inc2_b", 32'(Cout), 32'h02);
        chk("inc2_b_wrap", 32'(wrap), 32'h0);

        drive(1'b1, 8'h59, 1'b0, 2'b00);
        step();
        drive(1'b0, 8'h00, 1'b1, 2'b10);
        step();
        chk("inc2_max", 32'(Cout), 32'h01);
        chk("inc2_max_wrap", 32'(wrap), 32'h1);

        drive(1'b1, 8'h10, 1'b1, 2'b11);
        step();
        chk("ld10", 32'(Cout), 32'h10);
        drive(1'b0, 8'h00, 1'b1, 2'b11);
        step();
        chk("dec_a", 32'(Cout), 32'h09);
        chk("dec_a_wrap", 32'(wrap), 32'h0);
        step();
        chk("dec_b", 32'(Cout), 32'h08);
        drive(1'b1, 8'h00, 1'b0, 2'b00);
        step();
        chk("ld00", 32'(Cout), 32'h00);
        drive(1'b0, 8'h00, 1'b1, 2'b11);
        step();
        chk("dec_wrap", 32'(Cout), 32'h59);
        chk("dec_wrap_w", 32'(wrap), 32'h1);

        drive(1'b1, 8'h37, 1'b0, 2'b00);
        step();
        chk("ld37", 32'(Cout), 32'h37);
        chk("ld37_err", 32'(load_err), 32'h0);
        drive(1'b1, 8'h3A, 1'b1, 2'b01);
        step();
        chk("bad3A", 32'(Cout), 32'h37);
        chk("bad3A_err", 32'(load_err), 32'h1);
        drive(1'b1, 8'h60, 1'b1, 2'b01);
        step();
        chk("bad60", 32'(Cout), 32'h37);
        chk("bad60_err", 32'(load_err), 32'h1);
        drive(1'b0, 8'h00, 1'b0, 2'b01);
        step();
        chk("idle", 32'(Cout), 32'h37);
        chk("idle_err", 32'(load_err), 32'h0);
        drive(1'b0, 8'h00, 1'b1, 2'b00);
        step();
        chk("hold", 32'(Cout), 32'h37);
        chk("hold_wrap", 32'(wrap), 32'h0);

        drive(1'b1, 8'h42, 1'b0, 2'b00);
        step();
        chk("ld42", 32'(Cout), 32'h42);
        drive(1'b0, 8'h00, 1'b1, 2'b01);
        resetn = 1'b0;
        #1;
        chk("async_rst", 32'(Cout), 32'h00);
`ifdef MOD_COUNTER_SEG7_EN
        chk("async_hex", 32'(HEX), 32'h2040);
`endif
        step();
        chk("rst_hold", 32'(Cout), 32'h00);
        resetn = 1'b1;
        step();
        chk("post_rst", 32'(Cout), 32'h01);

        drive(1'b1, 8'h25, 1'b1, 2'b01);
        step();
        chk("ld_prio", 32'(Cout), 32'h25);
        chk("ld_prio_err", 32'(load_err), 32'h0);
`ifdef MOD_COUNTER_SEG7_EN
        chk("hex25", 32'(HEX), 32'({7'b0100100, 7'b0010010}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
